tokens_rr_arb: RTL

- Round-robin arbiter that shares one valid/ready sink, typically the src side of tokens_sfifo, between N requesters.
- Optional burst lock: a granted requester keeps the sink until it asserts last, or until MAXB beats have been sent.
- Registered output stage with 1-cycle latency and full throughput. Source index is forwarded with every beat.

---
 rtl/tokens_arb_pkg.sv | 36 +++
 rtl/tokens_rr_pick.sv | 29 ++
 rtl/tokens_rr_arb.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/tokens_arb_pkg.sv
// Shared types and helpers for the tokens round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE = free arbitration, LOCK = burst owner holds the sink)
//   rr_first()  : generic rotating first-one search used by the priority encoder
package tokens_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Widest request vector rr_first() can search.
    localparam int unsigned MaxReq = 32;

    // Returns the first set index of req[n-1:0], searching ptr, ptr+1, ... modulo n.
    // Returns 0 when no bit is set; callers qualify with |req.
    function automatic int unsigned rr_first(input logic [MaxReq-1:0] req,
                                             input int unsigned       ptr,
                                             input int unsigned       n);
        int unsigned idx;
        logic        found;
        rr_first = 0;
        found    = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            if (k < n) begin
                idx = ptr + k;
                // ptr < n and k < n, so one subtraction performs the wrap
                if (idx >= n) idx = idx - n;
                if (!found && req[idx]) begin
                    rr_first = idx;
                    found    = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/tokens_rr_pick.sv
// Combinational rotating-priority encoder.
//   req     : request vector, one bit per requester
//   ptr     : index holding highest priority this cycle
//   gnt     : first requesting index at or after ptr (wrapping)
//   gnt_vld : at least one request is present
module tokens_rr_pick
    import tokens_arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt,
    output logic          gnt_vld
);

    logic [MaxReq-1:0] req_ext;
    int unsigned       first;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        first          = rr_first(req_ext, 32'(ptr), N);
        gnt            = IW'(first);
        gnt_vld        = |req;
    end

endmodule

// File: rtl/tokens_rr_arb.sv
// Round-robin arbiter sharing one valid/ready sink between N requesters, with optional
// burst lock and a registered output stage (1-cycle latency, full throughput).
//   clk, rst_n        : clock, asynchronous active-low reset
//   src_vld/rdy/dat/lst : per-requester stream, requester i data at [i*DW +: DW]
//   dst_vld/rdy/dat/lst : merged output stream (registered)
//   dst_id            : index of the requester that produced the current beat
module tokens_rr_arb
    import tokens_arb_pkg::*;
#(
    parameter  int unsigned N    = 4,
    parameter  int unsigned DW   = 32,
    parameter  int unsigned MAXB = 8,
    localparam int unsigned IW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    src_vld,
    output logic [N-1:0]    src_rdy,
    input  logic [N*DW-1:0] src_dat,
    input  logic [N-1:0]    src_lst,
    output logic            dst_vld,
    input  logic            dst_rdy,
    output logic [DW-1:0]   dst_dat,
    output logic            dst_lst,
    output logic [IW-1:0]   dst_id
);

    localparam int unsigned CW = $clog2(MAXB) + 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          dst_vld_q;
    logic [DW-1:0] dst_dat_q;
    logic          dst_lst_q;
    logic [IW-1:0] dst_id_q;

    logic [IW-1:0] rr_gnt;
    logic          rr_gnt_vld;
    logic [IW-1:0] gnt;
    logic          gnt_vld;
    logic          ld;
    logic          xfer;

    tokens_rr_pick #(
        .N (N)
    ) u_pick (
        .req     (src_vld),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_vld (rr_gnt_vld)
    );

    // Output register can take a new beat when empty or being drained this cycle.
    assign ld = !dst_vld_q || dst_rdy;

    always_comb begin
        if (state_q == LOCK) begin
            // Owner keeps the sink even while its valid is low.
            gnt     = owner_q;
            gnt_vld = src_vld[owner_q];
        end else begin
            gnt     = rr_gnt;
            gnt_vld = rr_gnt_vld;
        end
    end

    always_comb begin
        src_rdy = '0;
        if (rst_n && ld && gnt_vld) src_rdy[gnt] = 1'b1;
    end

    assign xfer = |(src_vld & src_rdy);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    ptr_d = (gnt == IW'(N - 1)) ? '0 : gnt + 1'b1;
                    if (MAXB > 1 && !src_lst[gnt]) begin
                        state_d = LOCK;
                        owner_d = gnt;
                        cnt_d   = CW'(1);
                    end
                end
                LOCK: begin
                    // ptr already points past the owner, so release hands over fairly.
                    if (src_lst[gnt] || cnt_q == CW'(MAXB - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_vld_q <= 1'b0;
            dst_dat_q <= '0;
            dst_lst_q <= 1'b0;
            dst_id_q  <= '0;
        end else if (xfer) begin
            dst_vld_q <= 1'b1;
            dst_dat_q <= src_dat[gnt*DW +: DW];
            dst_lst_q <= src_lst[gnt];
            dst_id_q  <= gnt;
        end else if (dst_rdy) begin
            dst_vld_q <= 1'b0;
        end
    end

    assign dst_vld = dst_vld_q;
    assign dst_dat = dst_dat_q;
    assign dst_lst = dst_lst_q;
    assign dst_id  = dst_id_q;

endmodule
